// File: rtl/i2s_pkg.sv
// Shared widths, reset constants and sample-format helpers for the I2S transmit path.
// Also intended for a future i2s_rx.
package i2s_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int FRAME_BITS = 32;
    localparam int BIT_CNT_W  = 5;

    localparam logic [BIT_CNT_W-1:0] BIT_CNT_RST = BIT_CNT_W'(FRAME_BITS - 1);

    typedef logic [SAMPLE_W-1:0] sample_t;

    // Left word occupies the upper half so the frame can be shifted out MSB-first.
    typedef struct packed {
        sample_t l;
        sample_t r;
    } frame_t;

    function automatic sample_t to_wire_fmt(input sample_t s, input bit signed_in);
        sample_t res;
        res = s;
        if (!signed_in) begin
            res[SAMPLE_W-1] = ~s[SAMPLE_W-1];
        end
        return res;
    endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// Sample-pair handshake between a PCM producer and the I2S transmitter.
interface i2s_tx_if;

    i2s_pkg::sample_t sample_l;
    i2s_pkg::sample_t sample_r;
    logic             sample_valid;
    logic             sample_ready;

    modport master (
        output sample_l,
        output sample_r,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_l,
        input  sample_r,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/i2s_bclk_gen.sv
// System-clock divider producing a registered BCLK plus single-cycle strobes that
// mark the clk edge on which bclk rises or falls.
module i2s_bclk_gen #(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic bclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int unsigned     DIV_W  = 16;
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic             bclk_q;
    logic             bclk_d;
    logic             term_cnt;

    always_comb begin
        term_cnt  = (div_cnt_q == DIV_TC);
        div_cnt_d = div_cnt_q + 1'b1;
        bclk_d    = bclk_q;
        if (term_cnt) begin
            div_cnt_d = '0;
            bclk_d    = ~bclk_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

    // Strobes are combinational so the consumer updates on the same edge as bclk.
    assign rise_stb = term_cnt & ~bclk_q;
    assign fall_stb = term_cnt &  bclk_q;
    assign bclk     = bclk_q;

endmodule

// File: rtl/i2s_tx.sv
// Stereo I2S (Philips) transmitter: one-deep holding register, 32-bit frame shifter
// and word-select generation, all advanced on BCLK falling edges.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int unsigned BCLK_DIV  = 4,
    parameter bit          SIGNED_IN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    i2s_tx_if.slave    smp,
    output logic       bclk,
    output logic       lrclk,
    output logic       sdata,
    output logic       frame_start,
    output logic       underrun
);

    logic fall_stb;
    logic bclk_rise_unused;

    logic [BIT_CNT_W-1:0]  bit_cnt_q;
    logic [BIT_CNT_W-1:0]  bit_cnt_d;
    logic [FRAME_BITS-1:0] shift_q;
    logic [FRAME_BITS-1:0] shift_d;
    frame_t                hold_q;
    frame_t                hold_d;
    frame_t                last_q;
    frame_t                last_d;
    logic                  hold_valid_q;
    logic                  hold_valid_d;
    logic                  lrclk_q;
    logic                  lrclk_d;
    logic                  sdata_q;
    logic                  sdata_d;
    logic                  frame_start_q;
    logic                  frame_start_d;
    logic                  underrun_q;
    logic                  underrun_d;
    logic                  capture;

    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk      (clk),
        .rst      (rst),
        .bclk     (bclk),
        .rise_stb (bclk_rise_unused),
        .fall_stb (fall_stb)
    );

    always_comb begin
        capture       = smp.sample_valid && !hold_valid_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        hold_d        = hold_q;
        last_d        = last_q;
        hold_valid_d  = hold_valid_q;
        lrclk_d       = lrclk_q;
        sdata_d       = sdata_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;

        if (fall_stb) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            lrclk_d   = bit_cnt_d[BIT_CNT_W-1];
            sdata_d   = shift_q[FRAME_BITS-1];
            if (bit_cnt_d == '0) begin
                frame_start_d = 1'b1;
                if (hold_valid_q) begin
                    shift_d      = hold_q;
                    last_d       = hold_q;
                    hold_valid_d = 1'b0;
                end else begin
                    // Starved producer: repeat the previous frame rather than emit silence.
                    shift_d    = last_q;
                    underrun_d = 1'b1;
                end
            end else begin
                shift_d = shift_q << 1;
            end
        end

        // Capture only happens with hold empty, so it never collides with a load that drains hold.
        if (capture) begin
            hold_d.l     = to_wire_fmt(smp.sample_l, SIGNED_IN);
            hold_d.r     = to_wire_fmt(smp.sample_r, SIGNED_IN);
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt_q     <= BIT_CNT_RST;
            shift_q       <= '0;
            hold_q        <= '0;
            last_q        <= '0;
            hold_valid_q  <= 1'b0;
            lrclk_q       <= 1'b1;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            hold_q        <= hold_d;
            last_q        <= last_d;
            hold_valid_q  <= hold_valid_d;
            lrclk_q       <= lrclk_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign smp.sample_ready = ~hold_valid_q;
    assign lrclk            = lrclk_q;
    assign sdata            = sdata_q;
    assign frame_start      = frame_start_q;
    assign underrun         = underrun_q;

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Stereo I2S (Philips format) serial transmitter that consumes 16-bit PCM samples from the tone-generation stages (the sine LUT oscillator and similar) and drives an external audio DAC. It divides the system clock down to BCLK and generates LRCLK. Each sample pair is serialised MSB-first, one BCLK after each LRCLK transition. A one-deep holding register with a valid/ready handshake decouples producers from the serial frame timing.

## Interface
- BCLK_DIV, 4: system clocks per BCLK half-period; legal range 1..65535.
- SIGNED_IN, 1: 1 means inputs are two's complement; 0 means inputs are offset binary, and bit 15 is inverted on capture.

- clk  in  1: system clock; all logic on the rising edge.
- rst  in  1: reset, synchronous, active-low.
- sample_l  in  16: left sample.
- sample_r  in  16: right sample.
- sample_valid  in  1: producer presents a sample pair.
- sample_ready  out  1: holding register empty; equals !hold_valid.
- bclk  out  1: I2S bit clock, registered.
- lrclk  out  1: word select, registered; 0 = left, 1 = right.
- sdata  out  1: serial data, registered, changes only on BCLK falling edges.
- frame_start  out  1: one-cycle pulse on each frame load.
- underrun  out  1: one-cycle pulse when a frame loads with no new data.

## Operation
- **Divider:** div_cnt counts 0..BCLK_DIV-1. At the terminal count it wraps to 0 and bclk toggles.
  - Rise event: toggle with bclk=0.
  - Fall event (fe): toggle with bclk=1.
- **Bit counter:** bit_cnt is 5 bits and increments mod 32 on each fe. lrclk <= new bit_cnt[4], so lrclk changes on the same fe as bit_cnt wraps 15→16 and 31→0.
- **Shifter:** shift is 32 bits, sdata is 1 bit.
  - On every fe: sdata <= shift[31].
  - On fe where new bit_cnt==0 (the load fe): shift <= {L,R} frame.
  - On all other fe: shift <= shift<<1.
  - Result: the left MSB appears on sdata in slot 1. The right LSB appears in slot 0 of the next frame, which gives the Philips one-BCLK delay.
- **Holding register:** hold_l, hold_r, hold_valid.
  - Capture when sample_valid && sample_ready; hold_valid <= 1.
  - When SIGNED_IN=0, bit 15 of each sample is inverted on capture.
- **Frame load:**
  - If hold_valid=1: load {hold_l,hold_r}, clear hold_valid, pulse frame_start.
  - If hold_valid=0: reload the previous frame (last_l/last_r registers) and pulse both frame_start and underrun.
- **Simultaneous capture and load with hold_valid=0:** counts as an underrun. The new pair lands in hold and is used at the next frame.
- **Simultaneous load and capture with hold_valid=1:** no capture is possible, because ready=0 that cycle. Ready rises the next cycle.
- **Reset values:** div_cnt=0, bclk=0, bit_cnt=31, lrclk=1, shift=0, last_l=last_r=0, hold_valid=0, sdata=0, frame_start=0, underrun=0. sample_ready=1 in the first cycle after reset.
- **Reset asserted mid-frame:** aborts the frame immediately and returns all of the above to reset values on the next clk edge. There is no flush.

## Timing
- BCLK period = 2·BCLK_DIV clk cycles. Frame = 64·BCLK_DIV cycles. Sample rate = f_clk / (64·BCLK_DIV).
- **First edges after reset release (cycle 0 = first cycle with rst=1):**
  - First bclk rise visible after cycle BCLK_DIV-1.
  - First fe occurs at cycle 2·BCLK_DIV-1. At that fe, bit_cnt becomes 0, lrclk becomes 0, and the first frame loads.
  - With no sample present, that first load is an underrun of zeros.
- frame_start and underrun assert in the cycle after the load fe, as registered outputs, for exactly one cycle.
- Handshake latency: a sample accepted at any point before a load fe is transmitted in that frame. Left MSB appears at the fe one BCLK after the load fe.
- sdata and lrclk never change on a bclk rise.

## Structure
- Package i2s_pkg:
  - SAMPLE_W=16, FRAME_BITS=32, BIT_CNT_W=5.
  - Localparam for reset value of bit_cnt (FRAME_BITS-1).
- Sub-module i2s_bclk_gen: divider plus bclk register. Outputs bclk, rise_stb and fall_stb. Shared with a future i2s_rx.
- The top level holds bit_cnt, shifter, holding/last registers and handshake.

## Test plan
- **BCLK_DIV=4, reset then idle 600 cycles:**
  - bclk period 8 cycles, lrclk period 256 cycles.
  - underrun pulses every 256 cycles.
  - sdata constantly 0.
- **Present L=16'hA5C3, R=16'h0F01 before the first load fe:**
  - slots 1–16 of sdata = A5C3 MSB-first; slots 17–31 = R[15:1].
  - R bit 0 appears in slot 0 of the next frame.
  - No underrun.
- **Keep sample_valid high with incrementing L/R (0x0001, 0x0002, …):**
  - one acceptance per frame, consecutive values transmitted.
  - sample_ready low from capture until the load fe.
- **Drive sample_valid exactly in the load-fe cycle with hold empty:**
  - underrun pulse, previous frame repeated.
  - new pair transmitted in the following frame.
- **SIGNED_IN=0, input 16'h8000 on both channels:** serialised word is 16'h0000.
- **Assert rst for 1 cycle mid-slot 10 of the left word:**
  - the next cycle shows bclk=0, lrclk=1, sdata=0, sample_ready=1.
  - the first fe after release occurs 2·BCLK_DIV-1 cycles later.
